// File: rtl/anc_coef_mem_if.sv
// Coefficient-stream bus between the Wz coefficient store and the external LMS update logic.
interface anc_coef_mem_if #(
  parameter int CW = 11
);
  logic          FilterEN;
  logic [CW-1:0] WzIn;
  logic [CW-1:0] WzOut;
  logic          FiltComplete;

  modport master (
    output FilterEN,
    output WzIn,
    input  WzOut,
    input  FiltComplete
  );

  modport slave (
    input  FilterEN,
    input  WzIn,
    output WzOut,
    output FiltComplete
  );
endinterface

// File: rtl/anc_coef_mem.sv
// Adaptive-filter Wz coefficient store: streams every tap once per pass and writes back the LMS update.
// Optional write saturation to +/-COEF_LIMIT is enabled by defining ANC_COEF_CLAMP_EN.
module anc_coef_mem #(
  parameter int TAPS       = 16,
  parameter int CW         = 11,
  parameter int COEF_LIMIT = 511
) (
  input  logic           Clk_100M,
  input  logic           Reset,
  anc_coef_mem_if.slave  bus
);

  localparam int PW = $clog2(TAPS);
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

  if (TAPS < 2 || TAPS > 256) begin : g_bad_taps
    $error("anc_coef_mem: TAPS must be in 2..256");
  end
  if (COEF_LIMIT < 1 || COEF_LIMIT >= 2 ** (CW - 1)) begin : g_bad_limit
    $error("anc_coef_mem: COEF_LIMIT must fit CW-bit signed range");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_mem [TAPS];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_ptr_inc;
  logic [CW-1:0] r_wzout;
  logic [CW-1:0] w_wzout_nxt;
  logic [CW-1:0] w_wdata;
  logic          r_fc;
  logic          w_fc_nxt;
  logic          w_we;

  assign w_ptr_inc = r_ptr + 1'b1;

`ifdef ANC_COEF_CLAMP_EN
  localparam logic signed [CW-1:0] LIM_P = CW'(COEF_LIMIT);
  localparam logic signed [CW-1:0] LIM_N = CW'(-COEF_LIMIT);

  logic w_over;
  logic r_clamp_flag;

  always_comb begin
    w_over  = 1'b0;
    w_wdata = bus.WzIn;
    if ($signed(bus.WzIn) > LIM_P) begin
      w_wdata = LIM_P;
      w_over  = 1'b1;
    end else if ($signed(bus.WzIn) < LIM_N) begin
      w_wdata = LIM_N;
      w_over  = 1'b1;
    end
  end

  // Sticky saturation indicator; cleared only by Reset.
  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_clamp_flag <= 1'b0;
    end else if (w_we && w_over) begin
      r_clamp_flag <= 1'b1;
    end
  end
`else
  assign w_wdata = bus.WzIn;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_wzout_nxt = r_wzout;
    w_fc_nxt    = 1'b0;
    w_we        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.FilterEN) begin
          w_state_nxt = RUN;
          w_ptr_nxt   = '0;
          w_wzout_nxt = r_mem[0];
        end
      end
      RUN: begin
        if (bus.FilterEN) begin
          w_we = 1'b1;
          if (r_ptr == LAST) begin
            w_state_nxt = DONE;
            w_fc_nxt    = 1'b1;
          end else begin
            // Next tap is read before this edge's write lands; addresses differ, so no hazard.
            w_ptr_nxt   = w_ptr_inc;
            w_wzout_nxt = r_mem[w_ptr_inc];
          end
        end else begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = '0;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_wzout <= '0;
      r_fc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wzout <= w_wzout_nxt;
      r_fc    <= w_fc_nxt;
    end
  end

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[r_ptr] <= w_wdata;
    end
  end

  assign bus.WzOut        = r_wzout;
  assign bus.FiltComplete = r_fc;

endmodule

// File: tb/tb_anc_coef_mem.sv
// Directed, table-driven bench for anc_coef_mem (TAPS=16, CW=11); clamp expectations follow ANC_COEF_CLAMP_EN.
module tb_anc_coef_mem;

  localparam int TAPS = 16;
  localparam int CW   = 11;
  localparam int PASS = TAPS + 2;

`ifdef ANC_COEF_CLAMP_EN
  localparam logic signed [CW-1:0] BIG_IN  = 11'sd1000;
  localparam logic signed [CW-1:0] BIG_EXP = 11'sd511;
  localparam logic signed [CW-1:0] NEG_EXP = -11'sd511;
`else
  localparam logic signed [CW-1:0] BIG_IN  = 11'sd1023;
  localparam logic signed [CW-1:0] BIG_EXP = 11'sd1023;
  localparam logic signed [CW-1:0] NEG_EXP = -11'sd1000;
`endif
  localparam logic signed [CW-1:0] NEG_IN = -11'sd1000;

  typedef struct {
    logic                 en;
    logic signed [CW-1:0] wzin;
    logic signed [CW-1:0] exp_out;
    logic                 exp_fc;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];

  anc_coef_mem_if #(.CW(CW)) bus ();

  anc_coef_mem #(
    .TAPS      (TAPS),
    .CW        (CW),
    .COEF_LIMIT(511)
  ) dut (
    .Clk_100M(clk),
    .Reset   (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic signed [CW-1:0] exp_out, input logic exp_fc);
    n_cmp++;
    if (bus.WzOut !== exp_out || bus.FiltComplete !== exp_fc) begin
      n_err++;
      $display("FAIL %s[%0d]: WzOut=%0d FiltComplete=%b, want WzOut=%0d FiltComplete=%b",
               nm, idx, $signed(bus.WzOut), bus.FiltComplete, exp_out, exp_fc);
    end
  endtask

  task automatic step(input logic en, input logic signed [CW-1:0] wz);
    bus.FilterEN = en;
    bus.WzIn     = wz;
    @(posedge clk);
    #1;
  endtask

  // One full pass: taps below split expected to read lo, the rest hi.
  task automatic run_pass(input string nm, input logic signed [CW-1:0] wz, input int split,
                          input logic signed [CW-1:0] lo, input logic signed [CW-1:0] hi);
    for (int k = 1; k <= PASS; k++) begin
      step(1'b1, wz);
      if (k <= TAPS) chk(nm, k, (k - 1 < split) ? lo : hi, 1'b0);
      else           chk(nm, k, (TAPS - 1 < split) ? lo : hi, (k == TAPS + 1));
    end
  endtask

  task automatic add_pass(input logic signed [CW-1:0] wz, input logic signed [CW-1:0] shown);
    for (int k = 1; k <= PASS; k++) begin
      tbl.push_back('{en: 1'b1, wzin: wz, exp_out: shown, exp_fc: (k == TAPS + 1)});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    add_pass(11'sd100, 11'sd0);
    add_pass(11'sd100, 11'sd100);
    add_pass(11'sd10,  11'sd100);
    add_pass(11'sd10,  11'sd10);
    add_pass(BIG_IN,   11'sd10);
    add_pass(NEG_IN,   BIG_EXP);
    add_pass(11'sd0,   NEG_EXP);

    rst          = 1'b1;
    bus.FilterEN = 1'b0;
    bus.WzIn     = '0;
    #3;
    chk("por", 0, 11'sd0, 1'b0);
    #20;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 11'sd77);
      chk("idle_after_por", i, 11'sd0, 1'b0);
    end

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].wzin);
      chk("tbl", i, tbl[i].exp_out, tbl[i].exp_fc);
    end

    // Abort after tap 5 is presented; memory is all zero at this point.
    step(1'b1, 11'sd55);
    chk("abort_start", 0, 11'sd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 11'sd55);
      chk("abort_wr", i, 11'sd0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 11'sd55);
      chk("abort_idle", i, 11'sd0, 1'b0);
    end
    run_pass("reenable", 11'sd77, 5, 11'sd55, 11'sd0);

    // Reset mid-pass with ptr=8 and all taps holding 77.
    step(1'b1, 11'sd99);
    chk("rst_pass_start", 0, 11'sd77, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 11'sd99);
      chk("rst_pass_wr", i, 11'sd77, 1'b0);
    end
    #3;
    rst          = 1'b1;
    bus.FilterEN = 1'b0;
    #1;
    chk("rst_async", 0, 11'sd0, 1'b0);
    #299;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 11'sd33);
      chk("idle_after_rst", i, 11'sd0, 1'b0);
    end
    run_pass("after_rst", 11'sd5, 0, 11'sd0, 11'sd0);
    run_pass("after_rst2", 11'sd0, 0, 11'sd5, 11'sd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
